// File: rtl/mini_mips_pkg.sv
// Shared definitions for the mini MIPS core: sizes, opcode/funct encodings,
// ALU operations and the instruction decoder.
package mini_mips_pkg;

    localparam int unsigned Xlen     = 32;
    localparam int unsigned NumRegs  = 32;
    localparam int unsigned RegAddrW = 5;
    localparam int unsigned MemDepth = 1024;
    localparam int unsigned MemAddrW = 10;

    localparam logic [5:0] OpRtype = 6'b000000;
    localparam logic [5:0] OpAddi  = 6'b000001;
    localparam logic [5:0] OpJ     = 6'b000010;
    localparam logic [5:0] OpLw    = 6'b000111;
    localparam logic [5:0] OpSw    = 6'b001000;
    localparam logic [5:0] OpBeq   = 6'b001111;
    localparam logic [5:0] OpBne   = 6'b010000;

    localparam logic [5:0] FnSll = 6'b000000;
    localparam logic [5:0] FnSrl = 6'b000010;
    localparam logic [5:0] FnAdd = 6'b100000;
    localparam logic [5:0] FnSub = 6'b100010;
    localparam logic [5:0] FnAnd = 6'b100100;
    localparam logic [5:0] FnOr  = 6'b100101;
    localparam logic [5:0] FnXor = 6'b100110;
    localparam logic [5:0] FnSlt = 6'b101010;

    typedef enum logic [2:0] {
        AluAdd,
        AluSub,
        AluAnd,
        AluOr,
        AluXor,
        AluSlt,
        AluSll,
        AluSrl
    } alu_op_e;

    typedef struct packed {
        logic    reg_we;
        logic    mem_we;
        logic    mem_to_reg;
        logic    use_imm;
        logic    sw_base;   // address base comes from field A (sw) instead of field B
        logic    rtype;
        logic    beq;
        logic    bne;
        logic    jump;
        alu_op_e alu_op;
    } ctrl_t;

    // Unknown opcodes and functs fall through with every enable low, i.e. a nop.
    function automatic ctrl_t decode(input logic [5:0] opcode, input logic [5:0] funct);
        ctrl_t c;
        c        = '0;
        c.alu_op = AluAdd;
        case (opcode)
            OpRtype: begin
                c.rtype  = 1'b1;
                c.reg_we = 1'b1;
                case (funct)
                    FnSll:   c.alu_op = AluSll;
                    FnSrl:   c.alu_op = AluSrl;
                    FnAdd:   c.alu_op = AluAdd;
                    FnSub:   c.alu_op = AluSub;
                    FnAnd:   c.alu_op = AluAnd;
                    FnOr:    c.alu_op = AluOr;
                    FnXor:   c.alu_op = AluXor;
                    FnSlt:   c.alu_op = AluSlt;
                    default: c.reg_we = 1'b0;
                endcase
            end
            OpAddi: begin
                c.reg_we  = 1'b1;
                c.use_imm = 1'b1;
            end
            OpLw: begin
                c.reg_we     = 1'b1;
                c.use_imm    = 1'b1;
                c.mem_to_reg = 1'b1;
            end
            OpSw: begin
                c.mem_we  = 1'b1;
                c.use_imm = 1'b1;
                c.sw_base = 1'b1;
            end
            OpBeq:   c.beq  = 1'b1;
            OpBne:   c.bne  = 1'b1;
            OpJ:     c.jump = 1'b1;
            default: ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/mini_mips_regfile.sv
// 32x32 register file: two combinational read ports, one synchronous write
// port, asynchronous active-low clear, register 0 hardwired to zero.
module mini_mips_regfile
    import mini_mips_pkg::*;
(
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [RegAddrW-1:0] raddr_a_i,
    output logic [Xlen-1:0]     rdata_a_o,
    input  logic [RegAddrW-1:0] raddr_b_i,
    output logic [Xlen-1:0]     rdata_b_o,
    input  logic                we_i,
    input  logic [RegAddrW-1:0] waddr_i,
    input  logic [Xlen-1:0]     wdata_i
);

    logic [Xlen-1:0] regs_q [NumRegs];
    logic [Xlen-1:0] regs_d [NumRegs];

    always_comb begin
        regs_d = regs_q;
        if (we_i && (waddr_i != '0)) begin
            regs_d[waddr_i] = wdata_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NumRegs; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    assign rdata_a_o = (raddr_a_i == '0) ? '0 : regs_q[raddr_a_i];
    assign rdata_b_o = (raddr_b_i == '0) ? '0 : regs_q[raddr_b_i];

endmodule

// File: rtl/mini_mips_cpu.sv
// Single-cycle word-addressed MIPS-style core with host-loadable instruction
// and data memories and a debug view of reg[instr[20:16]].
module mini_mips_cpu
    import mini_mips_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic [Xlen-1:0]     inst_data,
    input  logic [MemAddrW-1:0] address,
    input  logic                write_instruction,
    input  logic                write_data,
    output logic [Xlen-1:0]     OutputOfRs
);

    logic [Xlen-1:0]     imem_q [MemDepth];
    logic [Xlen-1:0]     dmem_q [MemDepth];
    logic [MemAddrW-1:0] pc_q, pc_d;

    logic [Xlen-1:0]     instr;
    logic [5:0]          opcode;
    logic [5:0]          funct;
    logic [4:0]          shamt;
    logic [RegAddrW-1:0] field_a, field_b, field_rt;
    logic [Xlen-1:0]     imm_ext;
    ctrl_t               ctrl;

    logic [RegAddrW-1:0] rf_raddr_a;
    logic [Xlen-1:0]     rf_rdata_a, rf_rdata_b;
    logic [Xlen-1:0]     alu_a, alu_b, alu_res;
    logic [Xlen-1:0]     wb_data;

    logic                dmem_we;
    logic [MemAddrW-1:0] dmem_addr;
    logic [Xlen-1:0]     dmem_wdata, dmem_rdata;
    logic [MemAddrW-1:0] pc_plus1;
    logic                take_branch;

    always_comb begin
        instr    = imem_q[pc_q];
        opcode   = instr[31:26];
        field_a  = instr[25:21];
        field_b  = instr[20:16];
        field_rt = instr[15:11];
        shamt    = instr[10:6];
        funct    = instr[5:0];
        imm_ext  = {{(Xlen - 16){instr[15]}}, instr[15:0]};
        ctrl     = decode(opcode, funct);
    end

    // Port A serves rt for R-type and field A otherwise; port B always reads field B.
    assign rf_raddr_a = ctrl.rtype ? field_rt : field_a;

    mini_mips_regfile u_regfile (
        .clk_i     (clk),
        .rst_ni    (rst),
        .raddr_a_i (rf_raddr_a),
        .rdata_a_o (rf_rdata_a),
        .raddr_b_i (field_b),
        .rdata_b_o (rf_rdata_b),
        .we_i      (ctrl.reg_we),
        .waddr_i   (field_a),
        .wdata_i   (wb_data)
    );

    assign OutputOfRs = rf_rdata_b;

    always_comb begin
        alu_a = ctrl.sw_base ? rf_rdata_a : rf_rdata_b;
        alu_b = ctrl.use_imm ? imm_ext : rf_rdata_a;
        unique case (ctrl.alu_op)
            AluAdd: alu_res = alu_a + alu_b;
            AluSub: alu_res = alu_a - alu_b;
            AluAnd: alu_res = alu_a & alu_b;
            AluOr:  alu_res = alu_a | alu_b;
            AluXor: alu_res = alu_a ^ alu_b;
            AluSlt: alu_res = {{(Xlen - 1){1'b0}}, $signed(alu_a) < $signed(alu_b)};
            AluSll: alu_res = alu_b << shamt;
            AluSrl: alu_res = alu_b >> shamt;
            default: alu_res = '0;
        endcase
    end

    // The host port owns the data memory whenever write_data is high.
    always_comb begin
        dmem_addr  = write_data ? address : alu_res[MemAddrW-1:0];
        dmem_wdata = write_data ? inst_data : rf_rdata_b;
        dmem_we    = write_data | (ctrl.mem_we & rst);
        dmem_rdata = dmem_q[dmem_addr];
        wb_data    = ctrl.mem_to_reg ? dmem_rdata : alu_res;
    end

    always_ff @(posedge clk) begin
        if (write_instruction) begin
            imem_q[address] <= inst_data;
        end
        if (dmem_we) begin
            dmem_q[dmem_addr] <= dmem_wdata;
        end
    end

    always_comb begin
        pc_plus1    = pc_q + 10'd1;
        take_branch = (ctrl.beq && (rf_rdata_a == rf_rdata_b)) ||
                      (ctrl.bne && (rf_rdata_a != rf_rdata_b));
        pc_d        = pc_plus1;
        if (ctrl.jump) begin
            pc_d = instr[MemAddrW-1:0];
        end else if (take_branch) begin
            pc_d = pc_plus1 + imm_ext[MemAddrW-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

endmodule

// File: tb/tb_mini_mips_cpu.sv
// Directed bench for mini_mips_cpu: loads small programs through the host port
// and compares registers, data memory, PC and the debug port against hand values.
module tb_mini_mips_cpu;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_ADDI = 6'b000001;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_LW   = 6'b000111;
    localparam logic [5:0] OP_SW   = 6'b001000;
    localparam logic [5:0] OP_BEQ  = 6'b001111;
    localparam logic [5:0] OP_BNE  = 6'b010000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] inst_data = '0;
    logic [9:0]  address = '0;
    logic        write_instruction = 1'b0;
    logic        write_data = 1'b0;
    logic [31:0] out_rs;

    int passed = 0;
    int total  = 0;

    mini_mips_cpu dut (
        .clk               (clk),
        .rst               (rst),
        .inst_data         (inst_data),
        .address           (address),
        .write_instruction (write_instruction),
        .write_data        (write_data),
        .OutputOfRs        (out_rs)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] enc_i(input logic [5:0] op, input int a, input int b,
                                          input int imm);
        logic [4:0]  fa;
        logic [4:0]  fb;
        logic [15:0] fi;
        fa = a[4:0];
        fb = b[4:0];
        fi = imm[15:0];
        return {op, fa, fb, fi};
    endfunction

    function automatic logic [31:0] enc_r(input int rd, input int rs, input int rt,
                                          input int sh, input logic [5:0] fn);
        logic [4:0] fa;
        logic [4:0] fb;
        logic [4:0] fr;
        logic [4:0] fs;
        fa = rd[4:0];
        fb = rs[4:0];
        fr = rt[4:0];
        fs = sh[4:0];
        return {OP_R, fa, fb, fr, fs, fn};
    endfunction

    task automatic host_write(input logic to_imem, input logic to_dmem, input int addr,
                              input logic [31:0] data);
        write_instruction = to_imem;
        write_data        = to_dmem;
        address           = addr[9:0];
        inst_data         = data;
        @(posedge clk);
        #1;
        write_instruction = 1'b0;
        write_data        = 1'b0;
    endtask

    task automatic run(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Hold reset and zero both memories so every program starts from a known image.
    task automatic setup();
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 1024; i++) begin
            host_write(1'b1, 1'b1, i, 32'h0);
        end
    endtask

    task automatic test_reset();
        #2 rst = 1'b0;
        #1;
        total++;
        if (dut.pc_q !== 10'd0) $display("FAIL reset_pc: got %0d expected 0", dut.pc_q);
        else passed++;
        total++;
        if (out_rs !== 32'h0) $display("FAIL reset_out_rs: got %h expected 0", out_rs);
        else passed++;
        setup();
        host_write(1'b1, 1'b1, 100, 32'hA5A5_0001);
        total++;
        if (dut.imem_q[100] !== 32'hA5A5_0001 || dut.dmem_q[100] !== 32'hA5A5_0001)
            $display("FAIL dual_load: imem %h dmem %h expected a5a50001",
                     dut.imem_q[100], dut.dmem_q[100]);
        else passed++;
    endtask

    task automatic test_program();
        logic [31:0] prog [11];
        setup();
        prog[0]  = enc_i(OP_ADDI, 31, 0, 10);
        prog[1]  = 32'h0;
        prog[2]  = enc_i(OP_ADDI, 6, 0, 10);
        prog[3]  = enc_i(OP_BNE, 6, 31, 1);
        prog[4]  = enc_i(OP_ADDI, 8, 0, 1);
        prog[5]  = enc_i(OP_ADDI, 7, 0, 8);
        prog[6]  = enc_i(OP_SW, 0, 31, 0);
        prog[7]  = enc_i(OP_ADDI, 15, 0, 15);
        prog[8]  = enc_i(OP_SW, 31, 7, 5);
        prog[9]  = enc_i(OP_LW, 6, 0, 15);
        prog[10] = enc_i(OP_LW, 10, 0, 0);
        for (int i = 0; i < 11; i++) host_write(1'b1, 1'b0, i, prog[i]);
        rst = 1'b1;
        run(12);
        total++;
        if (dut.u_regfile.regs_q[31] !== 32'd10)
            $display("FAIL prog_r31: got %h expected 10", dut.u_regfile.regs_q[31]);
        else passed++;
        total++;
        if (dut.u_regfile.regs_q[7] !== 32'd8)
            $display("FAIL prog_r7: got %h expected 8", dut.u_regfile.regs_q[7]);
        else passed++;
        total++;
        if (dut.u_regfile.regs_q[8] !== 32'd1)
            $display("FAIL prog_r8_not_taken: got %h expected 1", dut.u_regfile.regs_q[8]);
        else passed++;
        total++;
        if (dut.u_regfile.regs_q[6] !== 32'd8)
            $display("FAIL prog_r6_lw: got %h expected 8", dut.u_regfile.regs_q[6]);
        else passed++;
        total++;
        if (dut.u_regfile.regs_q[10] !== 32'd10)
            $display("FAIL prog_r10_lw: got %h expected 10", dut.u_regfile.regs_q[10]);
        else passed++;
        total++;
        if (dut.dmem_q[0] !== 32'd10)
            $display("FAIL prog_dmem0: got %h expected 10", dut.dmem_q[0]);
        else passed++;
        total++;
        if (dut.dmem_q[15] !== 32'd8)
            $display("FAIL prog_dmem15: got %h expected 8", dut.dmem_q[15]);
        else passed++;
        total++;
        if (dut.pc_q !== 10'd12) $display("FAIL prog_pc: got %0d expected 12", dut.pc_q);
        else passed++;
    endtask

    // Relies on the state left behind by test_program.
    task automatic test_async_reset();
        logic all_zero;
        run(2);
        #2 rst = 1'b0;
        #1;
        total++;
        if (dut.pc_q !== 10'd0) $display("FAIL async_pc: got %0d expected 0", dut.pc_q);
        else passed++;
        all_zero = 1'b1;
        for (int i = 0; i < 32; i++) if (dut.u_regfile.regs_q[i] !== 32'h0) all_zero = 1'b0;
        total++;
        if (!all_zero) $display("FAIL async_regs: got nonzero r31=%h expected all 0",
                                dut.u_regfile.regs_q[31]);
        else passed++;
        total++;
        if (dut.dmem_q[0] !== 32'd10 || dut.dmem_q[15] !== 32'd8)
            $display("FAIL async_dmem: got %h/%h expected 10/8", dut.dmem_q[0], dut.dmem_q[15]);
        else passed++;
    endtask

    task automatic test_bne_taken();
        logic [31:0] prog [6];
        setup();
        prog[0] = enc_i(OP_ADDI, 6, 0, 5);
        prog[1] = enc_i(OP_ADDI, 31, 0, 10);
        prog[2] = 32'h0;
        prog[3] = enc_i(OP_BNE, 6, 31, 1);
        prog[4] = enc_i(OP_ADDI, 9, 0, 1);
        prog[5] = enc_i(OP_ADDI, 11, 0, 2);
        for (int i = 0; i < 6; i++) host_write(1'b1, 1'b0, i, prog[i]);
        rst = 1'b1;
        run(4);
        total++;
        if (dut.pc_q !== 10'd5) $display("FAIL bne_pc: got %0d expected 5", dut.pc_q);
        else passed++;
        run(1);
        total++;
        if (dut.u_regfile.regs_q[9] !== 32'h0)
            $display("FAIL bne_skipped: got %h expected 0", dut.u_regfile.regs_q[9]);
        else passed++;
        total++;
        if (dut.u_regfile.regs_q[11] !== 32'd2)
            $display("FAIL bne_target: got %h expected 2", dut.u_regfile.regs_q[11]);
        else passed++;
    endtask

    task automatic test_rtype();
        logic [31:0] prog [19];
        logic [31:0] exp_val [15];
        int          exp_reg [15];
        setup();
        prog[0]  = enc_i(OP_ADDI, 1, 0, 3);
        prog[1]  = enc_i(OP_ADDI, 2, 0, 5);
        prog[2]  = enc_r(3, 1, 2, 0, 6'b100010);
        prog[3]  = enc_i(OP_ADDI, 4, 0, -1);
        prog[4]  = enc_i(OP_ADDI, 5, 0, 1);
        prog[5]  = enc_r(6, 4, 5, 0, 6'b101010);
        prog[6]  = enc_i(OP_ADDI, 0, 0, 7);
        prog[7]  = enc_r(7, 0, 2, 4, 6'b000000);
        prog[8]  = enc_r(8, 0, 4, 28, 6'b000010);
        prog[9]  = enc_i(OP_BEQ, 1, 1, 1);
        prog[10] = enc_i(OP_ADDI, 9, 0, 1);
        prog[11] = {OP_J, 26'd14};
        prog[12] = enc_i(OP_ADDI, 10, 0, 1);
        prog[13] = enc_i(OP_ADDI, 10, 0, 2);
        prog[14] = enc_r(11, 1, 2, 0, 6'b100110);
        prog[15] = enc_r(12, 1, 2, 0, 6'b100100);
        prog[16] = enc_r(13, 1, 2, 0, 6'b100101);
        prog[17] = enc_r(14, 1, 2, 0, 6'b100000);
        prog[18] = 32'h0;
        for (int i = 0; i < 19; i++) host_write(1'b1, 1'b0, i, prog[i]);
        rst = 1'b1;
        run(15);
        exp_reg = '{3, 6, 7, 8, 9, 10, 11, 12, 13, 14, 1, 2, 4, 5, 15};
        exp_val = '{32'hFFFF_FFFE, 32'd1, 32'd80, 32'hF, 32'd0, 32'd0, 32'd6, 32'd1, 32'd7,
                    32'd8, 32'd3, 32'd5, 32'hFFFF_FFFF, 32'd1, 32'd0};
        for (int i = 0; i < 15; i++) begin
            total++;
            if (dut.u_regfile.regs_q[exp_reg[i]] !== exp_val[i])
                $display("FAIL rtype_r%0d: got %h expected %h", exp_reg[i],
                         dut.u_regfile.regs_q[exp_reg[i]], exp_val[i]);
            else passed++;
        end
        total++;
        if (dut.pc_q !== 10'd18) $display("FAIL rtype_pc: got %0d expected 18", dut.pc_q);
        else passed++;
        total++;
        if (out_rs !== 32'h0) $display("FAIL r0_reads_zero: got %h expected 0", out_rs);
        else passed++;
    endtask

    task automatic test_host_dmem();
        setup();
        host_write(1'b1, 1'b0, 0, enc_i(OP_ADDI, 1, 0, 20));
        host_write(1'b1, 1'b0, 1, enc_i(OP_ADDI, 2, 0, 32'h55));
        host_write(1'b1, 1'b0, 2, enc_i(OP_SW, 1, 2, 1));
        host_write(1'b1, 1'b0, 3, enc_i(OP_SW, 1, 2, 2));
        rst = 1'b1;
        run(2);
        host_write(1'b0, 1'b1, 20, 32'hDEAD_BEEF);
        run(1);
        total++;
        if (dut.dmem_q[20] !== 32'hDEAD_BEEF)
            $display("FAIL host_dmem20: got %h expected deadbeef", dut.dmem_q[20]);
        else passed++;
        total++;
        if (dut.dmem_q[21] !== 32'h0)
            $display("FAIL host_sw_dropped: got %h expected 0", dut.dmem_q[21]);
        else passed++;
        total++;
        if (dut.dmem_q[22] !== 32'h55)
            $display("FAIL host_next_sw: got %h expected 55", dut.dmem_q[22]);
        else passed++;
    endtask

    task automatic test_debug_port();
        setup();
        host_write(1'b1, 1'b0, 0, enc_i(OP_ADDI, 4, 0, 32'h1234));
        host_write(1'b1, 1'b0, 1, enc_i(OP_ADDI, 5, 4, 0));
        rst = 1'b1;
        #1;
        total++;
        if (out_rs !== 32'h0) $display("FAIL debug_pc0: got %h expected 0", out_rs);
        else passed++;
        run(1);
        total++;
        if (out_rs !== 32'h1234) $display("FAIL debug_out_rs: got %h expected 1234", out_rs);
        else passed++;
        run(1);
        total++;
        if (dut.u_regfile.regs_q[5] !== 32'h1234)
            $display("FAIL debug_r5: got %h expected 1234", dut.u_regfile.regs_q[5]);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_program();
        test_async_reset();
        test_bne_taken();
        test_rtype();
        test_host_dmem();
        test_debug_port();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
